// File: rtl/tick_pkg.sv
// Shared types and default parameters for the tick generator slice.
package tick_pkg;

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        RATE_0 = 2'd0,
        RATE_1 = 2'd1,
        RATE_2 = 2'd2,
        RATE_3 = 2'd3
    } rate_t;

    localparam int unsigned DB_CYCLES_DEF = 500000;
    localparam int unsigned CNT_W_DEF     = 26;
    localparam int unsigned DIV0_DEF      = 50000000;
    localparam int unsigned DIV1_DEF      = 25000000;
    localparam int unsigned DIV2_DEF      = 5000000;
    localparam int unsigned DIV3_DEF      = 1;

endpackage

// File: rtl/btn_debounce.sv
// Raw pushbutton conditioning: 2-FF synchronizer, stability counter and
// a single-cycle press event on the debounced rising edge.
module btn_debounce
    import tick_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic clear,
    input  logic raw,
    output logic level,
    output logic press_evt
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // press_evt is registered on the flip edge so it is visible in the
    // same cycle the new debounced level is.
    always_ff @(posedge clk) begin
        if (clear) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            level     <= 1'b0;
            press_evt <= 1'b0;
        end else begin
            sync1     <= raw;
            sync2     <= sync1;
            press_evt <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt       <= '0;
                level     <= ~level;
                press_evt <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Enable-pulse source for the hex counter: run/pause toggle, single step
// while paused, and a rate-selectable divider while running.
module tick_gen
    import tick_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned DIV0      = DIV0_DEF,
    parameter int unsigned DIV1      = DIV1_DEF,
    parameter int unsigned DIV2      = DIV2_DEF,
    parameter int unsigned DIV3      = DIV3_DEF
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       run_btn,
    input  logic       step_btn,
    input  logic [1:0] rate_sel,
    output logic       tick_out,
    output logic       running
);

    localparam logic [CNT_W-1:0] TC0 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] TC1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] TC2 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] TC3 = CNT_W'(DIV3 - 1);

    logic run_level, run_evt;
    logic step_level, step_evt;
    logic unused_levels;

    state_t           state;
    rate_t            rate_q;
    rate_t            rate_q2;
    logic             rate_chg;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] tc;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
        .clk       (clk),
        .clear     (clear),
        .raw       (run_btn),
        .level     (run_level),
        .press_evt (run_evt)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clk       (clk),
        .clear     (clear),
        .raw       (step_btn),
        .level     (step_level),
        .press_evt (step_evt)
    );

    assign unused_levels = run_level ^ step_level;
    assign rate_chg      = (rate_q != rate_q2);

    always_comb begin
        tc = TC0;
        case (rate_q)
            RATE_0:  tc = TC0;
            RATE_1:  tc = TC1;
            RATE_2:  tc = TC2;
            default: tc = TC3;
        endcase
    end

    // A run press on the terminal-count edge still emits that tick; the
    // state change and divider clear override the divider update below it.
    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= ST_PAUSE;
            running  <= 1'b0;
            tick_out <= 1'b0;
            div      <= '0;
            rate_q   <= RATE_0;
            rate_q2  <= RATE_0;
        end else begin
            rate_q   <= rate_t'(rate_sel);
            rate_q2  <= rate_q;
            tick_out <= 1'b0;
            case (state)
                ST_PAUSE: begin
                    div <= '0;
                    if (run_evt) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end else if (step_evt && !rate_chg) begin
                        tick_out <= 1'b1;
                    end
                end
                default: begin
                    if (rate_chg) begin
                        div <= '0;
                    end else if (div == tc) begin
                        div      <= '0;
                        tick_out <= 1'b1;
                    end else begin
                        div <= div + 1'b1;
                    end
                    if (run_evt) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                        div     <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// Directed and randomized checks of tick_gen against an edge-numbered
// behavioural reference model.
module tb_tick_gen;

    localparam int unsigned DB = 4;
    localparam int unsigned D0 = 10;
    localparam int unsigned D1 = 5;
    localparam int unsigned D2 = 3;
    localparam int unsigned D3 = 1;

    logic       clk = 1'b0;
    logic       clear;
    logic       run_btn;
    logic       step_btn;
    logic [1:0] rate_sel;
    logic       tick_out;
    logic       running;

    tick_gen #(
        .DB_CYCLES (DB),
        .CNT_W     (8),
        .DIV0      (D0),
        .DIV1      (D1),
        .DIV2      (D2),
        .DIV3      (D3)
    ) dut (
        .clk      (clk),
        .clear    (clear),
        .run_btn  (run_btn),
        .step_btn (step_btn),
        .rate_sel (rate_sel),
        .tick_out (tick_out),
        .running  (running)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;
    int unsigned tq[$];

    bit            m_tick = 1'b0;
    bit            m_run  = 1'b0;
    bit            m_lr   = 1'b0;
    bit            m_ls   = 1'b0;
    bit            m_er   = 1'b0;
    bit            m_es   = 1'b0;
    bit [DB+1:0]   m_hr   = '0;
    bit [DB+1:0]   m_hs   = '0;
    bit [1:0]      m_rq   = '0;
    bit [1:0]      m_rq2  = '0;
    int unsigned   m_epoch = 0;

    function automatic int unsigned period(input bit [1:0] r);
        case (r)
            2'd0:    return D0;
            2'd1:    return D1;
            2'd2:    return D2;
            default: return D3;
        endcase
    endfunction

    // Reference: a button level flips once the last DB synchronized samples
    // (raw delayed two edges) all disagree with it; ticks fall on edges that
    // are a whole number of periods after the last run start or rate change.
    always @(posedge clk) begin
        bit chg;
        cyc++;
        if (clear) begin
            m_tick = 0; m_run = 0; m_lr = 0; m_ls = 0; m_er = 0; m_es = 0;
            m_hr = '0; m_hs = '0; m_rq = '0; m_rq2 = '0; m_epoch = cyc;
        end else begin
            chg    = (m_rq != m_rq2);
            m_tick = 0;
            if (m_run) begin
                if (chg) m_epoch = cyc;
                else if ((cyc - m_epoch) % period(m_rq) == 0) m_tick = 1;
                if (m_er) m_run = 0;
            end else if (m_er) begin
                m_run   = 1;
                m_epoch = cyc;
            end else if (m_es && !chg) begin
                m_tick = 1;
            end
            m_rq2 = m_rq;
            m_rq  = rate_sel;
            m_hr  = {m_hr[DB:0], run_btn};
            m_hs  = {m_hs[DB:0], step_btn};
            m_er  = 0;
            m_es  = 0;
            if (m_hr[DB+1:2] == {DB{~m_lr}}) begin m_er = ~m_lr; m_lr = ~m_lr; end
            if (m_hs[DB+1:2] == {DB{~m_ls}}) begin m_es = ~m_ls; m_ls = ~m_ls; end
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b at edge %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int unsigned obs, input int unsigned exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d at edge %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int unsigned tq_at(input int unsigned i);
        return (i < tq.size()) ? tq[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic cyc_n(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            chk("tick_out_model", tick_out, m_tick);
            chk("running_model", running, m_run);
            if (tick_out === 1'b1) tq.push_back(cyc);
        end
    endtask

    task automatic wait_run(input logic want, output int unsigned at);
        at = 0;
        for (int unsigned i = 0; i < 40; i++) begin
            cyc_n(1);
            if (running === want) begin
                at = cyc;
                break;
            end
        end
        chk("wait_running", running, want);
    endtask

    task automatic pulse(input bit which_run, input int unsigned hold, input int unsigned gap);
        if (which_run) run_btn = 1'b1;
        else           step_btn = 1'b1;
        cyc_n(hold);
        run_btn  = 1'b0;
        step_btn = 1'b0;
        cyc_n(gap);
    endtask

    initial begin
        int unsigned r;
        int unsigned f;
        int unsigned k;

        // Reset held with both buttons pressed
        clear = 1'b1; run_btn = 1'b1; step_btn = 1'b1; rate_sel = 2'd0;
        cyc_n(2);
        chk("reset_tick", tick_out, 1'b0);
        chk("reset_running", running, 1'b0);
        clear = 1'b0; run_btn = 1'b0; step_btn = 1'b0;
        tq.delete();
        cyc_n(12);
        chk_int("post_reset_ticks", tq.size(), 0);
        chk("post_reset_running", running, 1'b0);
        pulse(0, DB + 2, DB + 4);
        chk_int("fresh_press_ticks", tq.size(), 1);

        // Glitch shorter than the debounce window
        tq.delete();
        pulse(0, 3, 12);
        chk_int("glitch_ticks", tq.size(), 0);

        // Long step press: single tick DB+2 edges after first raw sample
        k = cyc + 1;
        tq.delete();
        pulse(0, 10, 10);
        chk_int("step_tick_count", tq.size(), 1);
        chk_int("step_tick_edge", tq_at(0), k + DB + 2);

        // Run timing at rate 1
        rate_sel = 2'd1;
        cyc_n(3);
        run_btn = 1'b1;
        wait_run(1'b1, r);
        run_btn = 1'b0;
        tq.delete();
        cyc_n(16);
        chk_int("rate1_count", tq.size(), 3);
        chk_int("rate1_first", tq_at(0), r + D1);
        chk_int("rate1_second", tq_at(1), r + 2 * D1);
        chk_int("rate1_third", tq_at(2), r + 3 * D1);
        run_btn = 1'b1;
        wait_run(1'b0, f);
        run_btn = 1'b0;
        tq.delete();
        cyc_n(20);
        chk_int("paused_ticks", tq.size(), 0);

        // Rate change mid-period: 0 -> 2 when divider reaches 7
        rate_sel = 2'd0;
        cyc_n(3);
        run_btn = 1'b1;
        wait_run(1'b1, r);
        run_btn = 1'b0;
        cyc_n(6);
        rate_sel = 2'd2;
        tq.delete();
        cyc_n(12);
        chk_int("ratechg_count", tq.size(), 3);
        chk_int("ratechg_first", tq_at(0), r + 11);
        chk_int("ratechg_second", tq_at(1), r + 14);
        run_btn = 1'b1;
        wait_run(1'b0, f);
        run_btn = 1'b0;
        cyc_n(DB + 3);

        // Rate 3: tick every cycle in RUN
        rate_sel = 2'd3;
        cyc_n(3);
        run_btn = 1'b1;
        wait_run(1'b1, r);
        run_btn = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            cyc_n(1);
            chk("rate3_tick", tick_out, 1'b1);
        end
        run_btn = 1'b1;
        wait_run(1'b0, f);
        run_btn = 1'b0;
        cyc_n(8);

        // Run press lands on terminal count at rate 2
        rate_sel = 2'd2;
        cyc_n(3);
        run_btn = 1'b1;
        wait_run(1'b1, r);
        run_btn = 1'b0;
        cyc_n(8);
        run_btn = 1'b1;
        cyc_n(7);
        chk("coincide_tick", tick_out, 1'b1);
        chk("coincide_running", running, 1'b0);
        run_btn = 1'b0;
        cyc_n(8);

        // Run and step together in PAUSE, then step while RUN
        run_btn = 1'b1; step_btn = 1'b1;
        wait_run(1'b1, r);
        chk("both_no_step_tick", tick_out, 1'b0);
        run_btn = 1'b0; step_btn = 1'b0;
        cyc_n(8);
        tq.delete();
        step_btn = 1'b1;
        cyc_n(6);
        step_btn = 1'b0;
        cyc_n(24);
        chk_int("step_in_run_count", tq.size(), 10);
        chk_int("step_in_run_first", tq_at(0), r + 9);
        run_btn = 1'b1;
        wait_run(1'b0, f);
        run_btn = 1'b0;
        cyc_n(DB + 3);

        // Randomized traffic against the model
        for (int unsigned it = 0; it < 80; it++) begin
            case ($urandom_range(0, 5))
                0: pulse(1, $urandom_range(DB, DB + 4), $urandom_range(DB + 1, DB + 10));
                1: pulse(0, $urandom_range(DB, DB + 4), $urandom_range(DB + 1, DB + 10));
                2: pulse($urandom_range(0, 1) != 0, $urandom_range(1, DB - 1), DB + 2);
                3: begin
                    rate_sel = 2'($urandom_range(0, 3));
                    cyc_n($urandom_range(1, 12));
                end
                4: begin
                    clear = 1'b1;
                    cyc_n($urandom_range(1, 2));
                    clear = 1'b0;
                    cyc_n(2);
                end
                default: begin
                    for (int unsigned j = 0; j < 10; j++) begin
                        run_btn  = 1'($urandom);
                        step_btn = 1'($urandom);
                        cyc_n(1);
                    end
                    run_btn  = 1'b0;
                    step_btn = 1'b0;
                    cyc_n(DB + 2);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
